// File: rtl/memoria_pkg.sv
// Write-port operation encoding shared by the register bank and its op unit.
package memoria_pkg;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
endpackage

// File: rtl/register_op_unit.sv
// Combinational next-value unit for the register bank write port.
// wrap flags INC from all-ones and DEC from zero.
module register_op_unit
    import memoria_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);
    always_comb begin
        nxt  = cur;
        wrap = 1'b0;
        case (op)
            OP_LOAD:  nxt = wdata;
            OP_INC: begin
                nxt  = cur + WIDTH'(1);
                wrap = &cur;
            end
            OP_DEC: begin
                nxt  = cur - WIDTH'(1);
                wrap = ~|cur;
            end
            default:  nxt = '0;
        endcase
    end
endmodule

// File: rtl/register_bank_up.sv
// Bank of DEPTH registers with one operating write port and two combinational
// read ports, optional write-to-read bypass and optional hard-wired zero register.
module register_bank_up
    import memoria_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             we,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             ovf
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] cur_val, nxt_val;
    logic             wrap;
    logic             wr_ok;

    // Addresses that map to real storage (excludes the hard-wired zero register).
    function automatic logic addr_live(input logic [AW-1:0] a);
        logic in_range;
        in_range = ({{(32-AW){1'b0}}, a} < 32'(DEPTH));
        return in_range && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok   = we && addr_live(waddr);
    assign cur_val = addr_live(waddr) ? regs_q[waddr] : '0;

    register_op_unit #(.WIDTH(WIDTH)) u_op (
        .cur   (cur_val),
        .op    (op),
        .wdata (wdata),
        .nxt   (nxt_val),
        .wrap  (wrap)
    );

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_live(a)) begin
            if (BYPASS && sclr)
                v = '0;
            else if (BYPASS && wr_ok && (a == waddr))
                v = nxt_val;
            else
                v = regs_q[a];
        end
        return v;
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
        ovf_d = 1'b0;
        if (sclr) begin
            for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
        end else if (wr_ok) begin
            regs_d[waddr] = nxt_val;
            ovf_d         = wrap;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
endmodule

// File: doc/register_bank_up.md
Name: register_bank_up

Overview:
- Parametrised successor to the single 8-bit register: a bank of DEPTH registers, each WIDTH bits wide.
- One write port supports per-write operations: load, increment, decrement and clear.
- Two asynchronous read ports, with optional write-to-read bypass and optional hard-wired zero register.
- Sits in the memory subsystem as the general register storage for the datapath.

Parameters:
- WIDTH, 8, bit width of each register and of the data ports.
- DEPTH, 8, number of registers; must be at least 2.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- BYPASS, 1, when 1 a read of the address being written returns the value being written this cycle.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  asynchronous reset, active-low; clears every register and ovf.
- sclr  input  1  synchronous clear-all; has priority over we.
- we  input  1  write enable.
- op  input  2  write operation: 00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data; used only by LOAD.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- rdata_a  output  WIDTH  read data, port A; combinational.
- rdata_b  output  WIDTH  read data, port B; combinational.
- ovf  output  1  registered one-cycle pulse on INC wrap or DEC underflow.

Behaviour:
- Reset: clr=0 immediately forces all registers to 0 and ovf to 0, independent of clk. Hold persists while clr=0. Normal operation resumes at the first rising edge with clr=1.
- Priority at each rising edge (clr=1): sclr=1 clears all registers and sets ovf=0, ignoring we. Else if we=1 and waddr is valid, perform op on reg[waddr]. Else all registers hold.
- Write-port operations:
  - LOAD: reg <= wdata.
  - INC: reg <= reg+1, modulo 2^WIDTH.
  - DEC: reg <= reg-1, modulo 2^WIDTH.
  - CLEAR: reg <= 0.
- ovf: set to 1 for exactly one cycle after an INC on a register holding all-ones (result 0). Likewise after a DEC on a register holding 0 (result all-ones). 0 on every other cycle, including cycles with we=0.
- Latency: writes are visible on the read ports the cycle after the edge. Reads are combinational from the current address.
- Bypass (BYPASS=1): if we=1, sclr=0, and raddr_x==waddr (valid, not a zeroed reg 0), then rdata_x shows the post-op value combinationally in the same cycle. If sclr=1, both read ports show 0. BYPASS=0: read ports show stored contents only.
- ZERO_REG=1: address 0 always reads 0. Writes to address 0 are discarded and never raise ovf.
- Invalid address (waddr >= DEPTH, non-power-of-2 DEPTH): write discarded, no ovf. A read of an invalid address returns 0.
- Simultaneous read of the same address on A and B is legal; both ports return the same value.
- Arithmetic is unsigned. No saturation mode.

Decomposition:
- Shared package memoria_pkg holds the op encoding constants (OP_LOAD=2'b00, OP_INC=2'b01, OP_DEC=2'b10, OP_CLEAR=2'b11).
- One sub-module, register_op_unit: combinational; takes current value, op and wdata; returns next value and the wrap flag. It is instantiated once for the write port and its output is reused for bypass.
- Storage array, read multiplexers and ovf register stay in the top module.

Test Plan:
- Reset: pulse clr=0 mid-cycle after loading reg3=8'hA5 -> rdata_a (raddr_a=3) reads 8'h00 immediately, before any clk edge; ovf=0.
- Load and read back: LOAD reg2=8'h3C, next cycle raddr_a=2, raddr_b=2 -> both ports read 8'h3C.
- Wrap:
  - LOAD reg1=8'hFF, then INC reg1 -> reg1=8'h00; ovf=1 for one cycle, 0 the next.
  - DEC reg1 -> 8'hFF with ovf=1.
- Bypass (BYPASS=1): we=1, op=LOAD, waddr=5, wdata=8'h77, raddr_a=5 -> rdata_a=8'h77 in the same cycle. With BYPASS=0 the same stimulus gives the old value until the next cycle.
- Priority: we=1 INC reg4 together with sclr=1 -> all registers 0 and ovf=0 after the edge.
- ZERO_REG=1, DEPTH=6:
  - LOAD reg0=8'h12 -> reads 0.
  - LOAD waddr=7 -> no register changes.
  - raddr_b=7 -> reads 0.
